score_display: RTL and testbench



---
 rtl/score_pkg.sv | 33 +++
 rtl/seg7_decode.sv | 14 +
 rtl/score_display.sv | 131 +++++++++++++
 tb/tb_score_display.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared constants for the Pong score keeper: segment patterns, FSM state, BCD helpers.
package score_pkg;

    localparam int BCD_W = 4;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef enum logic {
        PLAY = 1'b0,
        WON  = 1'b1
    } state_t;

    // Decimal to packed BCD, up to four digits, digit 0 in the LSBs.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 4; i++) begin
            r[i*BCD_W +: BCD_W] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One active-low seven-segment digit: 4-bit hex value in, segments a..g out.
module seg7_decode
    import score_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = blank ? SEG_BLANK : SEG_DIGIT[value];
    end

endmodule

// File: rtl/score_display.sv
// BCD score keeper with win detection and direct seven-segment drive.
// Optional win blink enabled by defining SCORE_DISPLAY_BLINK_EN.
module score_display
    import score_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int WIN_SCORE = 10,
    parameter bit BLANK_LZ  = 1'b1,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    inc,
    output logic [BCD_W*DIGITS-1:0] score_bcd,
    output logic                    win,
    output logic [7*DIGITS-1:0]     display
);

    localparam int SW = BCD_W * DIGITS;
    localparam logic [15:0] WIN_BCD16 = to_bcd(WIN_SCORE);
    localparam logic [SW-1:0] WIN_BCD = WIN_BCD16[SW-1:0];

    state_t        state_q, state_d;
    logic [SW-1:0] score_d;
    logic [SW-1:0] bumped;
    logic          carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PLAY;
            score_bcd <= '0;
        end else begin
            state_q   <= state_d;
            score_bcd <= score_d;
        end
    end

    // Ripple BCD increment; all-nines wraps to zero.
    always_comb begin
        bumped = score_bcd;
        carry  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (carry) begin
                if (score_bcd[k*BCD_W +: BCD_W] == 4'd9) begin
                    bumped[k*BCD_W +: BCD_W] = 4'd0;
                end else begin
                    bumped[k*BCD_W +: BCD_W] = score_bcd[k*BCD_W +: BCD_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        score_d = score_bcd;
        if (clear) begin
            state_d = PLAY;
            score_d = '0;
        end else if (inc && state_q == PLAY) begin
            score_d = bumped;
            if (WIN_SCORE != 0 && bumped == WIN_BCD) begin
                state_d = WON;
            end
        end
    end

    always_comb begin
        win = (state_q == WON);
    end

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] blink_cnt;
    logic          vis;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            vis       <= 1'b1;
        end else if (clear || state_q == PLAY) begin
            blink_cnt <= '0;
            vis       <= 1'b1;
        end else if (blink_cnt == CW'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            vis       <= ~vis;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end
`else
    logic vis;
    assign vis = 1'b1;
`endif

    // A digit blanks when it and every higher digit are zero.
    logic [DIGITS-1:0] lz;
    logic              hz;

    always_comb begin
        lz = '0;
        hz = 1'b1;
        for (int k = DIGITS - 1; k > 0; k--) begin
            hz    = hz && (score_bcd[k*BCD_W +: BCD_W] == 4'd0);
            lz[k] = BLANK_LZ && hz;
        end
    end

    logic [7*DIGITS-1:0] seg_w;

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        seg7_decode u_dec (
            .value (score_bcd[k*BCD_W +: BCD_W]),
            .blank (lz[k] | ~vis),
            .seg   (seg_w[7*k +: 7])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DIGITS; k++) begin
                display[7*k +: 7] <= (k == 0 || !BLANK_LZ) ? SEG_DIGIT[0] : SEG_BLANK;
            end
        end else begin
            display <= seg_w;
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display: default instance plus a wrap/no-blank instance.
module tb_score_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] BL = 7'b1111111;

`ifdef SCORE_DISPLAY_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inc, clear, inc_w, clear_w;
    logic [7:0]  score, score_w;
    logic        win, win_w;
    logic [13:0] disp, disp_w;

    always #5 clk = ~clk;

    score_display #(
        .DIGITS(2), .WIN_SCORE(10), .BLANK_LZ(1'b1), .BLINK_DIV(4)
    ) dut (
        .clk(clk), .reset(rst), .clear(clear), .inc(inc),
        .score_bcd(score), .win(win), .display(disp)
    );

    score_display #(
        .DIGITS(2), .WIN_SCORE(0), .BLANK_LZ(1'b0), .BLINK_DIV(4)
    ) dut_w (
        .clk(clk), .reset(rst), .clear(clear_w), .inc(inc_w),
        .score_bcd(score_w), .win(win_w), .display(disp_w)
    );

    typedef struct packed {
        logic        sel;
        logic [7:0]  score;
        logic        win;
        logic        chk;
        logic [13:0] disp;
    } exp_t;

    exp_t  q[$];
    string nq[$];
    int    total = 0;
    int    pass  = 0;

    task automatic expect_out(input logic sel, input string name,
                              input logic [7:0] s, input logic w,
                              input logic chk, input logic [13:0] d);
        exp_t e;
        e.sel   = sel;
        e.score = s;
        e.win   = w;
        e.chk   = chk;
        e.disp  = d;
        q.push_back(e);
        nq.push_back(name);
    endtask

    task automatic cyc(input logic i, input logic c, input logic iw);
        inc   = i;
        clear = c;
        inc_w = iw;
        @(posedge clk);
        #1;
        inc   = 1'b0;
        clear = 1'b0;
        inc_w = 1'b0;
    endtask

    exp_t        m;
    string       mn;
    logic [7:0]  gs;
    logic        gw;
    logic [13:0] gd;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            m  = q.pop_front();
            mn = nq.pop_front();
            gs = m.sel ? score_w : score;
            gw = m.sel ? win_w : win;
            gd = m.sel ? disp_w : disp;
            total++;
            if (gs === m.score) pass++;
            else $display("FAIL %s score got %h want %h", mn, gs, m.score);
            total++;
            if (gw === m.win) pass++;
            else $display("FAIL %s win got %b want %b", mn, gw, m.win);
            if (m.chk) begin
                total++;
                if (gd === m.disp) pass++;
                else $display("FAIL %s display got %b want %b", mn, gd, m.disp);
            end
        end
    end

    initial begin
        rst = 1'b1;
        inc = 1'b0; clear = 1'b0; inc_w = 1'b0; clear_w = 1'b0;
        @(posedge clk);
        #1;
        expect_out(0, "reset", 8'h00, 0, 1, {BL, S0});
        expect_out(1, "reset_w", 8'h00, 0, 1, {S0, S0});
        @(posedge clk);
        #1;
        rst = 1'b0;

        cyc(1, 0, 0);
        expect_out(0, "first_inc", 8'h01, 0, 1, {BL, S0});
        repeat (8) cyc(1, 0, 0);
        expect_out(0, "nine", 8'h09, 0, 1, {BL, S8});
        cyc(0, 0, 0);
        expect_out(0, "nine_disp", 8'h09, 0, 1, {BL, S9});
        cyc(1, 0, 0);
        expect_out(0, "ten_win", 8'h10, 1, 1, {BL, S9});
        cyc(0, 0, 0);
        expect_out(0, "ten_disp", 8'h10, 1, 1, {S1, S0});
        repeat (5) cyc(1, 0, 0);
        expect_out(0, "win_hold", 8'h10, 1, !BLINK, {S1, S0});
        cyc(1, 1, 0);
        expect_out(0, "clr_prio", 8'h00, 0, !BLINK, {S1, S0});
        cyc(0, 0, 0);
        expect_out(0, "clr_disp", 8'h00, 0, 1, {BL, S0});
        cyc(1, 0, 0);
        expect_out(0, "replay", 8'h01, 0, 1, {BL, S0});

        repeat (99) cyc(0, 0, 1);
        expect_out(1, "w99", 8'h99, 0, 1, {S9, S8});
        cyc(0, 0, 0);
        expect_out(1, "w99_disp", 8'h99, 0, 1, {S9, S9});
        cyc(0, 0, 1);
        expect_out(1, "wrap", 8'h00, 0, 1, {S9, S9});
        cyc(0, 0, 0);
        expect_out(1, "wrap_disp", 8'h00, 0, 1, {S0, S0});

        repeat (2) cyc(1, 0, 0);
        expect_out(0, "pre_rst", 8'h03, 0, 1, {BL, 7'b0100100});
        inc = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        expect_out(0, "async_rst", 8'h00, 0, 1, {BL, S0});
        expect_out(1, "async_rst_w", 8'h00, 0, 1, {S0, S0});
        @(posedge clk);
        #1;
        rst = 1'b0;
        inc = 1'b0;

`ifdef SCORE_DISPLAY_BLINK_EN
        repeat (10) cyc(1, 0, 0);
        expect_out(0, "blink_win", 8'h10, 1, 0, {BL, BL});
        for (int j = 1; j <= 16; j++) begin
            cyc(0, 0, 0);
            if (((j - 1) / 4) % 2 == 0)
                expect_out(0, "blink_on", 8'h10, 1, 1, {S1, S0});
            else
                expect_out(0, "blink_off", 8'h10, 1, 1, {BL, BL});
        end
        cyc(0, 1, 0);
        expect_out(0, "blink_clr", 8'h00, 0, 0, {BL, BL});
        for (int j = 0; j < 8; j++) begin
            cyc(0, 0, 0);
            expect_out(0, "steady", 8'h00, 0, 1, {BL, S0});
        end
`endif

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain pending got %0d want 0", q.size());
        end
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

endmodule
